// File: rtl/harris_structure_tensor.sv
// Harris front end for one 5x5 window: Sobel gradients and products at the 9 interior
// positions (stage 1), then 3x3 Gaussian-weighted structure tensor sums (stage 2).
module harris_structure_tensor #(
    parameter int PIXEL_W = 8,
    parameter int GRAD_W  = 22,
    parameter int SUM_W   = 27
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [25*PIXEL_W-1:0]   window,
    output logic                    grad_valid,
    output logic [9*GRAD_W-1:0]     ixx_terms,
    output logic [9*GRAD_W-1:0]     iyy_terms,
    output logic [9*GRAD_W-1:0]     ixy_terms,
    output logic                    valid,
    output logic [SUM_W-1:0]        ixx,
    output logic [SUM_W-1:0]        iyy,
    output logic signed [SUM_W-1:0] ixy
);
    localparam int G_W = PIXEL_W + 3;

    logic signed [G_W-1:0]   w_gx [9];
    logic signed [G_W-1:0]   w_gy [9];
    logic [9*GRAD_W-1:0]     w_ixx_terms;
    logic [9*GRAD_W-1:0]     w_iyy_terms;
    logic [9*GRAD_W-1:0]     w_ixy_terms;
    logic [SUM_W-1:0]        w_sxx;
    logic [SUM_W-1:0]        w_syy;
    logic signed [SUM_W-1:0] w_sxy;

    logic                    r_grad_valid;
    logic [9*GRAD_W-1:0]     r_ixx_terms;
    logic [9*GRAD_W-1:0]     r_iyy_terms;
    logic [9*GRAD_W-1:0]     r_ixy_terms;
    logic                    r_valid;
    logic [SUM_W-1:0]        r_ixx;
    logic [SUM_W-1:0]        r_iyy;
    logic signed [SUM_W-1:0] r_ixy;

    function automatic logic signed [G_W-1:0] pix(input logic [25*PIXEL_W-1:0] win,
                                                  input int unsigned row,
                                                  input int unsigned col);
        return signed'({3'b000, win[(row*5+col)*PIXEL_W +: PIXEL_W]});
    endfunction

    // Gaussian weights 1/2/4 applied as left shifts
    function automatic int unsigned wshift(input int unsigned j);
        return (j == 4) ? 2 : ((j % 2 == 1) ? 1 : 0);
    endfunction

    always_comb begin
        w_gx        = '{default: '0};
        w_gy        = '{default: '0};
        w_ixx_terms = '0;
        w_iyy_terms = '0;
        w_ixy_terms = '0;
        for (int unsigned j = 0; j < 9; j++) begin
            w_gx[j] = (pix(window, j/3, j%3+2) + (pix(window, j/3+1, j%3+2) <<< 1)
                       + pix(window, j/3+2, j%3+2))
                    - (pix(window, j/3, j%3) + (pix(window, j/3+1, j%3) <<< 1)
                       + pix(window, j/3+2, j%3));
            w_gy[j] = (pix(window, j/3+2, j%3) + (pix(window, j/3+2, j%3+1) <<< 1)
                       + pix(window, j/3+2, j%3+2))
                    - (pix(window, j/3, j%3) + (pix(window, j/3, j%3+1) <<< 1)
                       + pix(window, j/3, j%3+2));
            w_ixx_terms[GRAD_W*j +: GRAD_W] = GRAD_W'(w_gx[j] * w_gx[j]);
            w_iyy_terms[GRAD_W*j +: GRAD_W] = GRAD_W'(w_gy[j] * w_gy[j]);
            w_ixy_terms[GRAD_W*j +: GRAD_W] = GRAD_W'(w_gx[j] * w_gy[j]);
        end
    end

    always_comb begin
        w_sxx = '0;
        w_syy = '0;
        w_sxy = '0;
        for (int unsigned j = 0; j < 9; j++) begin
            w_sxx = w_sxx + (SUM_W'(r_ixx_terms[GRAD_W*j +: GRAD_W]) << wshift(j));
            w_syy = w_syy + (SUM_W'(r_iyy_terms[GRAD_W*j +: GRAD_W]) << wshift(j));
            w_sxy = w_sxy + (SUM_W'(signed'(r_ixy_terms[GRAD_W*j +: GRAD_W])) <<< wshift(j));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grad_valid <= 1'b0;
            r_ixx_terms  <= '0;
            r_iyy_terms  <= '0;
            r_ixy_terms  <= '0;
            r_valid      <= 1'b0;
            r_ixx        <= '0;
            r_iyy        <= '0;
            r_ixy        <= '0;
        end else begin
            r_grad_valid <= start;
            r_valid      <= r_grad_valid;
            if (start) begin
                r_ixx_terms <= w_ixx_terms;
                r_iyy_terms <= w_iyy_terms;
                r_ixy_terms <= w_ixy_terms;
            end
            if (r_grad_valid) begin
                r_ixx <= w_sxx;
                r_iyy <= w_syy;
                r_ixy <= w_sxy;
            end
        end
    end

    assign grad_valid = r_grad_valid;
    assign ixx_terms  = r_ixx_terms;
    assign iyy_terms  = r_iyy_terms;
    assign ixy_terms  = r_ixy_terms;
    assign valid      = r_valid;
    assign ixx        = r_ixx;
    assign iyy        = r_iyy;
    assign ixy        = r_ixy;
endmodule

// File: tb/tb_harris_structure_tensor.sv
// Self-checking bench for harris_structure_tensor: directed spec windows, random windows
// against a 2D-convolution reference model, hold, back-to-back and mid-pipeline reset.
module tb_harris_structure_tensor;
    localparam int PIXEL_W = 8;
    localparam int GRAD_W  = 22;
    localparam int SUM_W   = 27;

    logic                    clk;
    logic                    rst_n;
    logic                    start;
    logic [25*PIXEL_W-1:0]   window;
    logic                    grad_valid;
    logic [9*GRAD_W-1:0]     ixx_terms;
    logic [9*GRAD_W-1:0]     iyy_terms;
    logic [9*GRAD_W-1:0]     ixy_terms;
    logic                    valid;
    logic [SUM_W-1:0]        ixx;
    logic [SUM_W-1:0]        iyy;
    logic signed [SUM_W-1:0] ixy;

    int total = 0;
    int bad   = 0;

    harris_structure_tensor #(.PIXEL_W(PIXEL_W), .GRAD_W(GRAD_W), .SUM_W(SUM_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .window(window),
        .grad_valid(grad_valid), .ixx_terms(ixx_terms), .iyy_terms(iyy_terms),
        .ixy_terms(ixy_terms), .valid(valid), .ixx(ixx), .iyy(iyy), .ixy(ixy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: 3x3 convolutions expressed with separable kernel weights
    function automatic int px(input logic [199:0] w, input int r, input int c);
        return int'(w[(r*5+c)*8 +: 8]);
    endfunction

    function automatic void grads(input logic [199:0] w, input int r, input int c,
                                  output int gx, output int gy);
        gx = 0;
        gy = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin
                gx += dc * (2 - dr*dr) * px(w, r+dr, c+dc);
                gy += dr * (2 - dc*dc) * px(w, r+dr, c+dc);
            end
    endfunction

    function automatic logic [3*SUM_W-1:0] model_sums(input logic [199:0] w);
        int gx, gy, sxx, syy, sxy, gw;
        sxx = 0; syy = 0; sxy = 0;
        for (int r = 1; r <= 3; r++)
            for (int c = 1; c <= 3; c++) begin
                grads(w, r, c, gx, gy);
                gw = (2 - (r-2)*(r-2)) * (2 - (c-2)*(c-2));
                sxx += gw * gx * gx;
                syy += gw * gy * gy;
                sxy += gw * gx * gy;
            end
        return {SUM_W'(sxx), SUM_W'(syy), SUM_W'(sxy)};
    endfunction

    function automatic logic [27*GRAD_W-1:0] model_terms(input logic [199:0] w);
        logic [9*GRAD_W-1:0] txx, tyy, txy;
        int gx, gy;
        for (int j = 0; j < 9; j++) begin
            grads(w, 1 + j/3, 1 + j%3, gx, gy);
            txx[GRAD_W*j +: GRAD_W] = GRAD_W'(gx * gx);
            tyy[GRAD_W*j +: GRAD_W] = GRAD_W'(gy * gy);
            txy[GRAD_W*j +: GRAD_W] = GRAD_W'(gx * gy);
        end
        return {txx, tyy, txy};
    endfunction

    // kind: 0 flat, 1 vertical step, 2 transposed step, 3 r+c, 4 c-r (+4 offset), 5 max step
    function automatic logic [199:0] mk(input int kind);
        logic [199:0] w;
        int v;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                case (kind)
                    0: v = 100;
                    1: v = (c >= 3) ? 10 : 0;
                    2: v = (r >= 3) ? 10 : 0;
                    3: v = r + c;
                    4: v = c - r + 4;
                    default: v = (c >= 2) ? 255 : 0;
                endcase
                w[(r*5+c)*8 +: 8] = 8'(v);
            end
        return w;
    endfunction

    function automatic logic [199:0] rand_win();
        logic [199:0] w;
        for (int i = 0; i < 25; i++)
            w[i*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        return w;
    endfunction

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        window = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (grad_valid !== 1'b0) begin bad++; $display("FAIL reset_grad_valid: got %b expected 0", grad_valid); end
        total++;
        if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", valid); end
        total++;
        if ({ixx_terms, iyy_terms, ixy_terms} !== '0) begin
            bad++; $display("FAIL reset_terms: got nonzero %h expected 0", {ixx_terms, iyy_terms, ixy_terms});
        end
        total++;
        if ({ixx, iyy, ixy} !== '0) begin
            bad++; $display("FAIL reset_sums: got %0d/%0d/%0d expected 0/0/0", ixx, iyy, ixy);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        int exp_xx[6] = '{0, 19200, 0, 1024, 1024, 12484800};
        int exp_yy[6] = '{0, 0, 19200, 1024, 1024, 0};
        int exp_xy[6] = '{0, 0, 0, 1024, -1024, 0};
        logic [199:0] w;
        for (int k = 0; k < 6; k++) begin
            w = mk(k);
            @(negedge clk);
            start  = 1'b1;
            window = w;
            @(posedge clk);
            #1;
            total++;
            if (grad_valid !== 1'b1 || valid !== 1'b0) begin
                bad++; $display("FAIL dir%0d_stage1_flags: got gv=%b v=%b expected gv=1 v=0", k, grad_valid, valid);
            end
            if (k == 1) begin
                total++;
                if (ixx_terms[0 +: GRAD_W] !== 22'd0 || ixx_terms[GRAD_W +: GRAD_W] !== 22'd1600
                    || ixx_terms[2*GRAD_W +: GRAD_W] !== 22'd1600) begin
                    bad++;
                    $display("FAIL vstep_terms: got j0=%0d j1=%0d j2=%0d expected 0/1600/1600",
                             ixx_terms[0 +: GRAD_W], ixx_terms[GRAD_W +: GRAD_W], ixx_terms[2*GRAD_W +: GRAD_W]);
                end
            end
            @(negedge clk);
            start  = 1'b0;
            window = '0;
            @(posedge clk);
            #1;
            total++;
            if (valid !== 1'b1 || grad_valid !== 1'b0) begin
                bad++; $display("FAIL dir%0d_valid: got v=%b gv=%b expected v=1 gv=0", k, valid, grad_valid);
            end
            total++;
            if ({ixx, iyy, ixy} !== {SUM_W'(exp_xx[k]), SUM_W'(exp_yy[k]), SUM_W'(exp_xy[k])}) begin
                bad++;
                $display("FAIL dir%0d_sums: got %0d/%0d/%0d expected %0d/%0d/%0d",
                         k, ixx, iyy, ixy, exp_xx[k], exp_yy[k], exp_xy[k]);
            end
            total++;
            if ({ixx, iyy, ixy} !== model_sums(w)) begin
                bad++; $display("FAIL dir%0d_model: got %h expected %h", k, {ixx, iyy, ixy}, model_sums(w));
            end
        end
    endtask

    task automatic test_random();
        logic [199:0] w;
        for (int n = 0; n < 30; n++) begin
            w = rand_win();
            @(negedge clk);
            start  = 1'b1;
            window = w;
            @(posedge clk);
            #1;
            total++;
            if ({ixx_terms, iyy_terms, ixy_terms} !== model_terms(w) || grad_valid !== 1'b1) begin
                bad++;
                $display("FAIL rand%0d_terms: got gv=%b %h expected gv=1 %h", n, grad_valid,
                         {ixx_terms, iyy_terms, ixy_terms}, model_terms(w));
            end
            @(negedge clk);
            start  = 1'b0;
            window = rand_win();
            @(posedge clk);
            #1;
            total++;
            if ({ixx, iyy, ixy} !== model_sums(w) || valid !== 1'b1) begin
                bad++;
                $display("FAIL rand%0d_sums: got v=%b %0d/%0d/%0d expected v=1 %h", n, valid,
                         ixx, iyy, ixy, model_sums(w));
            end
        end
    endtask

    task automatic test_hold();
        logic [199:0] w;
        w = rand_win();
        @(negedge clk);
        start  = 1'b1;
        window = w;
        @(negedge clk);
        start  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            window = rand_win();
        end
        @(posedge clk);
        #1;
        total++;
        if (grad_valid !== 1'b0 || valid !== 1'b0) begin
            bad++; $display("FAIL hold_flags: got gv=%b v=%b expected 0/0", grad_valid, valid);
        end
        total++;
        if ({ixx_terms, iyy_terms, ixy_terms} !== model_terms(w)) begin
            bad++; $display("FAIL hold_terms: got %h expected %h", {ixx_terms, iyy_terms, ixy_terms}, model_terms(w));
        end
        total++;
        if ({ixx, iyy, ixy} !== model_sums(w)) begin
            bad++; $display("FAIL hold_sums: got %h expected %h", {ixx, iyy, ixy}, model_sums(w));
        end
    endtask

    task automatic test_back_to_back();
        logic [199:0] ws[3];
        ws[0] = mk(0);
        ws[1] = mk(1);
        ws[2] = mk(3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start  = (i < 3);
            window = (i < 3) ? ws[i] : '0;
            @(posedge clk);
            #1;
            if (i >= 1 && i <= 3) begin
                total++;
                if (valid !== 1'b1 || {ixx, iyy, ixy} !== model_sums(ws[i-1])) begin
                    bad++;
                    $display("FAIL b2b%0d: got v=%b %0d/%0d/%0d expected v=1 %h", i, valid,
                             ixx, iyy, ixy, model_sums(ws[i-1]));
                end
            end else begin
                total++;
                if (valid !== 1'b0) begin bad++; $display("FAIL b2b%0d_idle: got v=%b expected 0", i, valid); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [199:0] w;
        w = mk(5);
        @(negedge clk);
        start  = 1'b1;
        window = w;
        @(posedge clk);
        #2;
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if (grad_valid !== 1'b0 || valid !== 1'b0 || {ixx_terms, iyy_terms, ixy_terms} !== '0
            || {ixx, iyy, ixy} !== '0) begin
            bad++; $display("FAIL midreset_clear: got gv=%b v=%b sums=%h expected all 0", grad_valid, valid, {ixx, iyy, ixy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (valid !== 1'b0 || {ixx, iyy, ixy} !== '0) begin
            bad++; $display("FAIL midreset_no_pulse: got v=%b sums=%h expected 0", valid, {ixx, iyy, ixy});
        end
        @(negedge clk);
        start  = 1'b1;
        window = w;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (valid !== 1'b1 || ixx !== 27'd12484800 || {ixx, iyy, ixy} !== model_sums(w)) begin
            bad++; $display("FAIL midreset_restart: got v=%b ixx=%0d expected v=1 ixx=12484800", valid, ixx);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
